// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe controller: FSM states,
// result codes, the eight winning-line masks and the fallback cell picker.
package ttt_pkg;

  localparam int CELLS = 9;

  typedef enum logic [2:0] {
    S_X_TURN, S_X_CHECK, S_O_THINK, S_O_CHECK, S_OVER
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00, W_X = 2'b01, W_O = 2'b10, W_DRAW = 2'b11
  } winner_e;

  // Index order: rows 0-2, cols 3-5, main diagonal 6, anti-diagonal 7
  localparam logic [7:0][CELLS-1:0] WIN_MASK = {
    9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
  };

  function automatic logic [CELLS-1:0] first_empty(input logic [CELLS-1:0] occ);
    logic [CELLS-1:0] f;
    f = ~occ;
    return f & (~f + 9'd1);
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// X-move handshake between the cursor/input logic (master) and the game controller (slave).
interface ttt_game_ctrl_if;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic       move_err;

  modport master (output move_valid, move_idx, input move_ready, move_err);
  modport slave  (input move_valid, move_idx, output move_ready, move_err);
endinterface

// File: rtl/ttt_line_check.sv
// Combinational line detector: flags any complete line on one player's board
// and reports the lowest-index complete line as one-hot.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [CELLS-1:0] board,
  output logic             win,
  output logic [7:0]       line
);
  logic [7:0] hit;

  for (genvar i = 0; i < 8; i++) begin : g_line
    assign hit[i] = (board & WIN_MASK[i]) == WIN_MASK[i];
  end

  assign win  = |hit;
  assign line = hit & (~hit + 8'd1);
endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: human X via valid/ready, automatic O via an external
// combinational generator. Define TTT_THINK_DELAY_EN to stretch O's turn by THINK_CYCLES.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int THINK_CYCLES = 25_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_game,
  ttt_game_ctrl_if.slave      mv,
  output logic [CELLS-1:0]    ai_x,
  output logic [CELLS-1:0]    ai_o,
  input  logic [CELLS-1:0]    ai_move,
  output logic [CELLS-1:0]    x_board,
  output logic [CELLS-1:0]    o_board,
  output logic                x_turn,
  output logic                game_over,
  output logic [1:0]          winner,
  output logic [7:0]          win_line
);
  if (THINK_CYCLES < 1) begin : g_bad_cfg
    $error("THINK_CYCLES must be at least 1");
  end

  state_e           state, state_d;
  winner_e          win_q, win_d;
  logic [CELLS-1:0] x_q, x_d, o_q, o_d;
  logic [7:0]       line_q, line_d;
  logic             err_q, err_d;
  logic [3:0]       cnt, cnt_d;

  logic [CELLS-1:0] occ, x_cell, o_pick;
  logic [15:0]      idx_dec;
  logic             legal, ai_ok, full;
  logic             x_win, o_win;
  logic [7:0]       x_line, o_line;

`ifdef TTT_THINK_DELAY_EN
  localparam int TW = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          tdone, tdone_d;
`endif

  ttt_line_check u_x_chk (.board(x_q), .win(x_win), .line(x_line));
  ttt_line_check u_o_chk (.board(o_q), .win(o_win), .line(o_line));

  assign occ     = x_q | o_q;
  assign full    = (cnt == 4'd9);
  assign idx_dec = 16'd1 << mv.move_idx;
  assign x_cell  = idx_dec[CELLS-1:0];
  assign legal   = (mv.move_idx <= 4'd8) && ((x_cell & occ) == '0);
  // Generator output is trusted only if one-hot and on an empty cell
  assign ai_ok   = (ai_move != '0) && ((ai_move & (ai_move - 9'd1)) == '0) &&
                   ((ai_move & occ) == '0);
  assign o_pick  = ai_ok ? ai_move : first_empty(occ);

  always_comb begin
    state_d       = state;
    x_d           = x_q;
    o_d           = o_q;
    win_d         = win_q;
    line_d        = line_q;
    err_d         = 1'b0;
    cnt_d         = cnt;
    mv.move_ready = (state == S_X_TURN) && !new_game;
`ifdef TTT_THINK_DELAY_EN
    tcnt_d        = tcnt;
    tdone_d       = tdone;
`endif
    if (new_game) begin
      state_d = S_X_TURN;
      x_d     = '0;
      o_d     = '0;
      win_d   = W_NONE;
      line_d  = '0;
      cnt_d   = '0;
`ifdef TTT_THINK_DELAY_EN
      tcnt_d  = '0;
      tdone_d = 1'b0;
`endif
    end else begin
      case (state)
        S_X_TURN: if (mv.move_valid) begin
          if (legal) begin
            x_d     = x_q | x_cell;
            cnt_d   = cnt + 4'd1;
            state_d = S_X_CHECK;
          end else begin
            err_d = 1'b1;
          end
        end
        S_X_CHECK: begin
          if (x_win) begin
            state_d = S_OVER;
            win_d   = W_X;
            line_d  = x_line;
          end else if (full) begin
            state_d = S_OVER;
            win_d   = W_DRAW;
          end else begin
            state_d = S_O_THINK;
`ifdef TTT_THINK_DELAY_EN
            tcnt_d  = '0;
            tdone_d = 1'b0;
`endif
          end
        end
        S_O_THINK: begin
`ifdef TTT_THINK_DELAY_EN
          // tdone adds the final wait cycle the narrow counter cannot represent
          if (!tdone) begin
            if (tcnt == TW'(THINK_CYCLES - 1)) tdone_d = 1'b1;
            else                               tcnt_d  = tcnt + 1'b1;
          end else begin
            o_d     = o_q | o_pick;
            cnt_d   = cnt + 4'd1;
            state_d = S_O_CHECK;
          end
`else
          o_d     = o_q | o_pick;
          cnt_d   = cnt + 4'd1;
          state_d = S_O_CHECK;
`endif
        end
        S_O_CHECK: begin
          if (o_win) begin
            state_d = S_OVER;
            win_d   = W_O;
            line_d  = o_line;
          end else if (full) begin
            state_d = S_OVER;
            win_d   = W_DRAW;
          end else begin
            state_d = S_X_TURN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_X_TURN;
      x_q    <= '0;
      o_q    <= '0;
      win_q  <= W_NONE;
      line_q <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
`ifdef TTT_THINK_DELAY_EN
      tcnt   <= '0;
      tdone  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      x_q    <= x_d;
      o_q    <= o_d;
      win_q  <= win_d;
      line_q <= line_d;
      err_q  <= err_d;
      cnt    <= cnt_d;
`ifdef TTT_THINK_DELAY_EN
      tcnt   <= tcnt_d;
      tdone  <= tdone_d;
`endif
    end
  end

  assign mv.move_err = err_q;
  assign ai_x        = x_q;
  assign ai_o        = o_q;
  assign x_board     = x_q;
  assign o_board     = o_q;
  assign x_turn      = (state == S_X_TURN);
  assign game_over   = (state == S_OVER);
  assign winner      = win_q;
  assign win_line    = line_q;
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: latency, wins, illegal moves, generator fallback,
// draw, new_game priority and async reset during O's turn.
module tb_ttt_game_ctrl;
`ifdef TTT_THINK_DELAY_EN
  localparam int TH = 8;
`else
  localparam int TH = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic [8:0] ai_x, ai_o, ai_move, x_board, o_board;
  logic       x_turn, game_over;
  logic [1:0] winner;
  logic [7:0] win_line;
  int         checks = 0;
  int         failures = 0;

  ttt_game_ctrl_if mif ();

  ttt_game_ctrl #(.THINK_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .mv(mif),
    .ai_x(ai_x), .ai_o(ai_o), .ai_move(ai_move),
    .x_board(x_board), .o_board(o_board), .x_turn(x_turn),
    .game_over(game_over), .winner(winner), .win_line(win_line)
  );

  always #5 clk = ~clk;

  task automatic offer(input logic [3:0] idx);
    @(negedge clk);
    mif.move_valid = 1'b1;
    mif.move_idx   = idx;
    @(negedge clk);
    mif.move_valid = 1'b0;
  endtask

  task automatic wait_turn();
    int n = 0;
    while (!x_turn && !game_over && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!x_turn && !game_over) begin
      checks++; failures++;
      $display("FAIL wait_turn timeout after %0d cycles", n);
    end
  endtask

  task automatic play(input logic [3:0] idx, input logic [8:0] ai);
    ai_move = ai;
    offer(idx);
    wait_turn();
  endtask

  task automatic ng();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (x_board !== 9'h0 || o_board !== 9'h0) begin failures++; $display("FAIL rst_boards x=%h o=%h exp 0", x_board, o_board); end
    checks++; if (winner !== 2'b00 || win_line !== 8'h0) begin failures++; $display("FAIL rst_result w=%b l=%h exp 00/00", winner, win_line); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mif.move_ready !== 1'b1 || x_turn !== 1'b1 || game_over !== 1'b0 || mif.move_err !== 1'b0)
      begin failures++; $display("FAIL rst_flags rdy=%b xt=%b go=%b err=%b exp 1100", mif.move_ready, x_turn, game_over, mif.move_err); end
  endtask

  task automatic test_latency();
    ai_move = 9'h001;
    @(negedge clk);
    checks++; if (mif.move_ready !== 1'b1) begin failures++; $display("FAIL lat_ready_n act=%b exp 1", mif.move_ready); end
    mif.move_valid = 1'b1; mif.move_idx = 4'd4;
    @(negedge clk); mif.move_valid = 1'b0;
    checks++; if (x_board !== 9'h010 || o_board !== 9'h0) begin failures++; $display("FAIL lat_n1 x=%h o=%h exp 010/000", x_board, o_board); end
    checks++; if (mif.move_ready !== 1'b0) begin failures++; $display("FAIL lat_n1_ready act=%b exp 0", mif.move_ready); end
    @(negedge clk);
    repeat (TH) @(negedge clk);
    checks++; if (o_board !== 9'h0) begin failures++; $display("FAIL lat_n2 o=%h exp 000", o_board); end
    @(negedge clk);
    checks++; if (o_board !== 9'h001 || mif.move_ready !== 1'b0) begin failures++; $display("FAIL lat_n3 o=%h rdy=%b exp 001/0", o_board, mif.move_ready); end
    @(negedge clk);
    checks++; if (mif.move_ready !== 1'b1 || x_turn !== 1'b1) begin failures++; $display("FAIL lat_n4 rdy=%b xt=%b exp 1/1", mif.move_ready, x_turn); end
  endtask

  task automatic test_x_win();
    ng();
    play(4'd0, 9'h008);
    play(4'd1, 9'h010);
    play(4'd2, 9'h000);
    checks++; if (winner !== 2'b01 || win_line !== 8'h01) begin failures++; $display("FAIL xwin_result w=%b l=%h exp 01/01", winner, win_line); end
    checks++; if (game_over !== 1'b1 || mif.move_ready !== 1'b0) begin failures++; $display("FAIL xwin_state go=%b rdy=%b exp 1/0", game_over, mif.move_ready); end
    checks++; if (x_board !== 9'h007 || o_board !== 9'h018) begin failures++; $display("FAIL xwin_boards x=%h o=%h exp 007/018", x_board, o_board); end
    offer(4'd5);
    repeat (3) @(negedge clk);
    checks++; if (x_board !== 9'h007 || winner !== 2'b01 || game_over !== 1'b1) begin failures++; $display("FAIL xwin_hold x=%h w=%b go=%b exp 007/01/1", x_board, winner, game_over); end
  endtask

  task automatic test_o_win();
    ng();
    play(4'd0, 9'h008);
    play(4'd1, 9'h010);
    play(4'd8, 9'h020);
    checks++; if (winner !== 2'b10 || win_line !== 8'h02 || game_over !== 1'b1) begin failures++; $display("FAIL owin w=%b l=%h go=%b exp 10/02/1", winner, win_line, game_over); end
  endtask

  task automatic test_illegal();
    logic [3:0] bad [3];
    bad[0] = 4'd4; bad[1] = 4'd4; bad[2] = 4'd12;
    ng();
    play(4'd4, 9'h001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mif.move_valid = 1'b1; mif.move_idx = bad[i];
      @(negedge clk); mif.move_valid = 1'b0;
      checks++; if (mif.move_err !== 1'b1) begin failures++; $display("FAIL ill_pulse%0d err=%b exp 1", i, mif.move_err); end
      @(negedge clk);
      checks++; if (mif.move_err !== 1'b0) begin failures++; $display("FAIL ill_clear%0d err=%b exp 0", i, mif.move_err); end
      checks++; if (x_board !== 9'h010 || o_board !== 9'h001 || x_turn !== 1'b1) begin failures++; $display("FAIL ill_state%0d x=%h o=%h xt=%b exp 010/001/1", i, x_board, o_board, x_turn); end
    end
  endtask

  task automatic test_fallback();
    ng();
    play(4'd4, 9'h003);
    checks++; if (o_board !== 9'h001) begin failures++; $display("FAIL fb_not_onehot o=%h exp 001", o_board); end
    play(4'd8, 9'h010);
    checks++; if (o_board !== 9'h003 || x_board !== 9'h110) begin failures++; $display("FAIL fb_occupied x=%h o=%h exp 110/003", x_board, o_board); end
  endtask

  task automatic test_draw_new_game();
    ng();
    play(4'd0, 9'h010);
    play(4'd2, 9'h002);
    play(4'd7, 9'h040);
    play(4'd3, 9'h020);
    play(4'd8, 9'h000);
    checks++; if (winner !== 2'b11 || win_line !== 8'h00 || game_over !== 1'b1) begin failures++; $display("FAIL draw w=%b l=%h go=%b exp 11/00/1", winner, win_line, game_over); end
    checks++; if (x_board !== 9'h18D || o_board !== 9'h072) begin failures++; $display("FAIL draw_boards x=%h o=%h exp 18d/072", x_board, o_board); end
    @(negedge clk);
    new_game = 1'b1; mif.move_valid = 1'b1; mif.move_idx = 4'd4;
    #1;
    checks++; if (mif.move_ready !== 1'b0) begin failures++; $display("FAIL ng_ready rdy=%b exp 0", mif.move_ready); end
    @(negedge clk);
    new_game = 1'b0; mif.move_valid = 1'b0;
    checks++; if (x_board !== 9'h0 || o_board !== 9'h0 || winner !== 2'b00 || win_line !== 8'h0) begin failures++; $display("FAIL ng_clear x=%h o=%h w=%b l=%h exp 0", x_board, o_board, winner, win_line); end
    checks++; if (x_turn !== 1'b1 || game_over !== 1'b0) begin failures++; $display("FAIL ng_state xt=%b go=%b exp 1/0", x_turn, game_over); end
    @(negedge clk);
    checks++; if (x_board !== 9'h0) begin failures++; $display("FAIL ng_move_taken x=%h exp 000", x_board); end
  endtask

  task automatic test_reset_mid_think();
    ng();
    ai_move = 9'h002;
    offer(4'd0);
    @(negedge clk);
    repeat (TH / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (x_board !== 9'h0 || o_board !== 9'h0 || x_turn !== 1'b1) begin failures++; $display("FAIL rmid_clear x=%h o=%h xt=%b exp 0/0/1", x_board, o_board, x_turn); end
    @(negedge clk);
    rst_n = 1'b1;
    ai_move = 9'h001;
    offer(4'd4);
    @(negedge clk);
    repeat (TH) @(negedge clk);
    checks++; if (o_board !== 9'h0) begin failures++; $display("FAIL rmid_early o=%h exp 000", o_board); end
    @(negedge clk);
    checks++; if (o_board !== 9'h001 || x_board !== 9'h010) begin failures++; $display("FAIL rmid_commit x=%h o=%h exp 010/001", x_board, o_board); end
  endtask

  initial begin
    mif.move_valid = 1'b0;
    mif.move_idx   = 4'd0;
    ai_move        = 9'h0;
    test_reset();
    test_latency();
    test_x_win();
    test_o_win();
    test_illegal();
    test_fallback();
    test_draw_new_game();
    test_reset_mid_think();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
